// File: rtl/rom_load_pkg.sv
// Shared types and default constants for
// the ROM download scheduler.
package rom_load_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } fsm_t;

  typedef struct packed {
    logic [24:0] addr;
    logic [7:0]  data;
  } ld_entry_t;

  localparam int LD_W = $bits(ld_entry_t);

  localparam logic [24:0] DEF_GFX_BASE  = 25'h10000;
  localparam logic [7:0]  DEF_ROM_INDEX = 8'd0;

endpackage

// File: rtl/rom_load_scheduler_if.sv
// data_io download bus plus the two SDRAM
// toggle-handshake write ports.
interface rom_load_scheduler_if;

  logic        ioctl_downl;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;

  logic        port1_req;
  logic        port1_ack;
  logic [22:0] port1_a;
  logic [1:0]  port1_ds;
  logic [15:0] port1_d;

  logic        port2_req;
  logic        port2_ack;
  logic [23:0] port2_a;
  logic [1:0]  port2_ds;
  logic [15:0] port2_d;

  logic        port_we;

  modport master (
    input  ioctl_downl, ioctl_index,
    input  ioctl_wr, ioctl_addr, ioctl_dout,
    input  port1_ack, port2_ack,
    output port1_req, port1_a,
    output port1_ds, port1_d,
    output port2_req, port2_a,
    output port2_ds, port2_d,
    output port_we
  );

  modport slave (
    output ioctl_downl, ioctl_index,
    output ioctl_wr, ioctl_addr, ioctl_dout,
    output port1_ack, port2_ack,
    input  port1_req, port1_a,
    input  port1_ds, port1_d,
    input  port2_req, port2_a,
    input  port2_ds, port2_d,
    input  port_we
  );

endinterface

// File: rtl/rom_load_scheduler_fifo.sv
// Single-clock show-ahead FIFO; pointers carry
// one extra wrap bit to tell full from empty.
module byte_fifo #(
  parameter int W  = 33,
  parameter int AW = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);

  localparam int D = 1 << AW;

  logic [W-1:0] mem_q [D];
  logic [AW:0]  wp_q, wp_d;
  logic [AW:0]  rp_q, rp_d;

  assign empty = (wp_q == rp_q);
  assign full  = (wp_q[AW] != rp_q[AW]) &&
                 (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign dout  = mem_q[rp_q[AW-1:0]];

  always_comb begin
    wp_d = wp_q;
    rp_d = rp_q;
    if (push && !full)
      wp_d = wp_q + (AW+1)'(1);
    if (pop && !empty)
      rp_d = rp_q + (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full)
      mem_q[wp_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/rom_load_scheduler.sv
// Buffers ROM download bytes and writes each one
// to SDRAM port1 (CPU) or port2 (GFX) by toggle req/ack.
module rom_load_scheduler
  import rom_load_pkg::*;
#(
  parameter int          FIFO_AW     = 3,
  parameter logic [24:0] GFX_BASE    = DEF_GFX_BASE,
  parameter logic [7:0]  ROM_INDEX   = DEF_ROM_INDEX,
  parameter int          ACK_TIMEOUT = 255
) (
  input  logic clk_sys,
  input  logic reset_n,
  rom_load_scheduler_if.master bus,
  output logic busy,
  output logic rom_loaded,
  output logic overflow,
  output logic timeout
);

  localparam int WD_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX =
    WD_W'(ACK_TIMEOUT);

  fsm_t state_q, state_d;

  logic wr_q, wr_d;
  logic downl_q, downl_d;
  logic ran_q, ran_d;
  logic sel_q, sel_d;
  logic req1_q, req1_d;
  logic req2_q, req2_d;
  logic sh1_q, sh1_d;
  logic sh2_q, sh2_d;
  logic [22:0] a1_q, a1_d;
  logic [1:0]  ds1_q, ds1_d;
  logic [15:0] d1_q, d1_d;
  logic [23:0] a2_q, a2_d;
  logic [1:0]  ds2_q, ds2_d;
  logic [15:0] d2_q, d2_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic loaded_q, loaded_d;
  logic ovf_q, ovf_d;
  logic to_q, to_d;

  logic            push, empty, full;
  logic [LD_W-1:0] fifo_dout;
  ld_entry_t       ent;
  logic [24:0]     rel;
  logic            is_gfx;
  logic            ack_ok, expire, rise;
  logic            pop, issue, wd_run, force_sh;

  assign push = !wr_q && bus.ioctl_wr &&
                bus.ioctl_downl &&
                (bus.ioctl_index == ROM_INDEX);

  byte_fifo #(
    .W  (LD_W),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk     (clk_sys),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .din     ({bus.ioctl_addr, bus.ioctl_dout}),
    .dout    (fifo_dout),
    .empty   (empty),
    .full    (full)
  );

  assign ent    = ld_entry_t'(fifo_dout);
  assign is_gfx = (ent.addr >= GFX_BASE);
  assign rel    = ent.addr - GFX_BASE;
  assign rise   = bus.ioctl_downl && !downl_q;

  // The shadow lets a timed-out port look complete.
  assign ack_ok = sel_q ?
    ((bus.port2_ack ^ sh2_q) == req2_q) :
    ((bus.port1_ack ^ sh1_q) == req1_q);
  assign expire = (wd_q == WD_MAX);

  always_ff @(posedge clk_sys) begin
    if (!reset_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!empty) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (ack_ok || expire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pop      = 1'b0;
    issue    = 1'b0;
    wd_run   = 1'b0;
    force_sh = 1'b0;
    unique case (1'b1)
      state_q == IDLE:  pop = !empty;
      state_q == ISSUE: issue = 1'b1;
      state_q == WAIT: begin
        wd_run   = !ack_ok && !expire;
        force_sh = !ack_ok && expire;
      end
      default: ;
    endcase
  end

  always_comb begin
    wr_d     = bus.ioctl_wr;
    downl_d  = bus.ioctl_downl;
    ran_d    = ran_q;
    sel_d    = sel_q;
    req1_d   = req1_q;
    req2_d   = req2_q;
    sh1_d    = sh1_q;
    sh2_d    = sh2_q;
    a1_d     = a1_q;
    ds1_d    = ds1_q;
    d1_d     = d1_q;
    a2_d     = a2_q;
    ds2_d    = ds2_q;
    d2_d     = d2_q;
    wd_d     = wd_q;
    loaded_d = loaded_q;
    ovf_d    = ovf_q;
    to_d     = to_q;

    if (pop) begin
      sel_d = is_gfx;
      wd_d  = '0;
      if (is_gfx) begin
        a2_d  = {rel[24:17], rel[14:0], rel[16]};
        ds2_d = {rel[15], ~rel[15]};
        d2_d  = {ent.data, ent.data};
      end else begin
        a1_d  = ent.addr[23:1];
        ds1_d = {ent.addr[0], ~ent.addr[0]};
        d1_d  = {ent.data, ent.data};
      end
    end

    if (issue) begin
      if (sel_q) req2_d = ~req2_q;
      else       req1_d = ~req1_q;
    end

    if (wd_run)
      wd_d = wd_q + WD_W'(1);

    if (rise) begin
      loaded_d = 1'b0;
      ovf_d    = 1'b0;
      to_d     = 1'b0;
      ran_d    = 1'b1;
    end

    if (force_sh) begin
      to_d = 1'b1;
      if (sel_q) sh2_d = bus.port2_ack ^ req2_q;
      else       sh1_d = bus.port1_ack ^ req1_q;
    end

    if (push && full)
      ovf_d = 1'b1;

    if (ran_q && !bus.ioctl_downl &&
        empty && state_q == IDLE)
      loaded_d = 1'b1;
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      wr_q     <= 1'b0;
      downl_q  <= 1'b0;
      ran_q    <= 1'b0;
      sel_q    <= 1'b0;
      req1_q   <= 1'b0;
      req2_q   <= 1'b0;
      sh1_q    <= 1'b0;
      sh2_q    <= 1'b0;
      a1_q     <= '0;
      ds1_q    <= '0;
      d1_q     <= '0;
      a2_q     <= '0;
      ds2_q    <= '0;
      d2_q     <= '0;
      wd_q     <= '0;
      loaded_q <= 1'b0;
      ovf_q    <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      wr_q     <= wr_d;
      downl_q  <= downl_d;
      ran_q    <= ran_d;
      sel_q    <= sel_d;
      req1_q   <= req1_d;
      req2_q   <= req2_d;
      sh1_q    <= sh1_d;
      sh2_q    <= sh2_d;
      a1_q     <= a1_d;
      ds1_q    <= ds1_d;
      d1_q     <= d1_d;
      a2_q     <= a2_d;
      ds2_q    <= ds2_d;
      d2_q     <= d2_d;
      wd_q     <= wd_d;
      loaded_q <= loaded_d;
      ovf_q    <= ovf_d;
      to_q     <= to_d;
    end
  end

  assign busy = bus.ioctl_downl || !empty ||
                (state_q != IDLE);

  assign bus.port_we   = busy;
  assign bus.port1_req = req1_q;
  assign bus.port1_a   = a1_q;
  assign bus.port1_ds  = ds1_q;
  assign bus.port1_d   = d1_q;
  assign bus.port2_req = req2_q;
  assign bus.port2_a   = a2_q;
  assign bus.port2_ds  = ds2_q;
  assign bus.port2_d   = d2_q;

  assign rom_loaded = loaded_q;
  assign overflow   = ovf_q;
  assign timeout    = to_q;

endmodule
